// File: rtl/ifb_pkg.sv
// Shared types and defaults for the instruction-fetch buffer.
package ifb_pkg;

   localparam int IFB_DEPTH = 4;
   localparam int IFB_XLEN  = 32;

   // Canonical NOP (addi x0, x0, 0); decode inserts it on a trap or bubble.
   localparam logic [31:0] IFB_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [IFB_XLEN-1:0] pc;
      logic [IFB_XLEN-1:0] instr;
      logic                exc;
   } ifb_entry_t;

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO of packed fetch entries with single-cycle clear and a
// combinationally readable head entry.
module ifb_fifo
   import ifb_pkg::*;
#(
   parameter int DEPTH = IFB_DEPTH,
   parameter int W     = $bits(ifb_entry_t)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr_reg] <= push_data;
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-fetch buffer: one in-flight memory read slot feeding a small FIFO.
// Optional IFB_MISALIGN_TRAP_EN flags misaligned PCs and suppresses their read.
module ifetch_buffer
   import ifb_pkg::*;
#(
   parameter int DEPTH = IFB_DEPTH,
   parameter int XLEN  = IFB_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_valid_i,
   output logic            pc_ready_o,
   input  logic [XLEN-1:0] pc_i,
   output logic            imem_en_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o,
   output logic            exc_o,
   input  logic            branch_taken_i
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int          EW      = 2 * XLEN + 1;
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   logic            accept;
   logic            pop;
   logic            push;
   logic [AW:0]     count;
   logic [AW:0]     occupancy;
   logic [EW-1:0]   entry_in;
   logic [EW-1:0]   head;
   logic            inflight_reg;
   logic [XLEN-1:0] inflight_pc_reg;
   logic [XLEN-1:0] fetch_instr;
   logic            fetch_exc;

   // Reserving a slot for the in-flight read guarantees its response always fits.
   assign occupancy   = count + {{AW{1'b0}}, inflight_reg};
   assign pc_ready_o  = ~branch_taken_i & (occupancy < DEPTH_C);
   assign accept      = pc_valid_i & pc_ready_o;
   assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};

   assign valid_o = (count != '0) & ~branch_taken_i;
   assign pop     = valid_o & ready_i;
   assign push    = inflight_reg & ~branch_taken_i;

`ifdef IFB_MISALIGN_TRAP_EN
   logic inflight_exc_reg;

   assign imem_en_o   = accept & (pc_i[1:0] == 2'b00);
   assign fetch_exc   = inflight_exc_reg;
   assign fetch_instr = inflight_exc_reg ? '0 : imem_rdata_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         inflight_exc_reg <= 1'b0;
      else if (accept) inflight_exc_reg <= (pc_i[1:0] != 2'b00);
   end
`else
   assign imem_en_o   = accept;
   assign fetch_exc   = 1'b0;
   assign fetch_instr = imem_rdata_i;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
      end else begin
         inflight_reg <= accept & ~branch_taken_i;
         if (accept) inflight_pc_reg <= pc_i;
      end
   end

   assign entry_in = {inflight_pc_reg, fetch_instr, fetch_exc};

   ifb_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (branch_taken_i),
      .push      (push),
      .push_data (entry_in),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign pc_o    = head[EW-1 -: XLEN];
   assign instr_o = head[XLEN:1];
   assign exc_o   = head[0];

endmodule
